// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Request/grant bundle between bus sources and bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int NREQ = 24
) ();
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [4:0]      grant_id;
    logic            bus_busy;
    logic            timeout;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  bus_busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output bus_busy,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin single-owner bus arbiter with one-cycle turnaround.
//                Optional forced release after MAX_HOLD cycles when the macro
//                BUS_ARBITER_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NREQ     = 24,
    parameter int MAX_HOLD = 16
) (
    input  wire logic    clock,
    input  wire logic    resetn,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ID = 5'(NREQ - 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [4:0]      grant_id_q, grant_id_d;
    logic [4:0]      ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] w_hi_req;
    logic [4:0]      w_lo_win;
    logic [4:0]      w_hi_win;
    logic [4:0]      w_win;
    logic            w_owner_req;
    logic            w_hold_expired;

    // Requests at or above ptr win first; otherwise wrap to the lowest index.
    assign w_hi_req = bus.req & ({NREQ{1'b1}} << ptr_q);

    always_comb begin
        w_lo_win = '0;
        w_hi_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i])  w_lo_win = 5'(i);
            if (w_hi_req[i]) w_hi_win = 5'(i);
        end
    end

    assign w_win       = (|w_hi_req) ? w_hi_win : w_lo_win;
    assign w_owner_req = |(bus.req & grant_q);

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign w_hold_expired = (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        hold_d = '0;
        unique case (state_q)
            IDLE:    hold_d = (|bus.req) ? HOLD_W'(1) : '0;
            GRANT:   hold_d = hold_q + HOLD_W'(1);
            default: hold_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) hold_q <= '0;
        else         hold_q <= hold_d;
    end
`else
    assign w_hold_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = GRANT;
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    grant_id_d = w_win;
                    busy_d     = 1'b1;
                end
            end
            GRANT: begin
                if (!w_owner_req || w_hold_expired) begin
                    state_d    = TURN;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    ptr_d      = (grant_id_q == LAST_ID) ? 5'd0 : grant_id_q + 5'd1;
                    timeout_d  = w_owner_req && w_hold_expired;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter (vectors, corner cases,
//                randomized traffic against a round-robin reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    localparam int NREQ     = 24;
    localparam int MAX_HOLD = 16;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    bus_arbiter_if #(.NREQ(NREQ)) bif ();

    bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, where the search starts, how long held.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_turn;
    bit m_to;

    typedef struct {
        bit              rst;
        logic [NREQ-1:0] req;
        int              exp_id;
        bit              exp_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_turn  = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input logic [NREQ-1:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || (TO_EN && m_held >= MAX_HOLD)) begin
                m_to    = r[m_owner];
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_turn  = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (r != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_held  = 1;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, "_grant"},   32'(bif.grant),    eg);
        chk({tag, "_id"},      32'(bif.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, "_busy"},    32'(bif.bus_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk({tag, "_timeout"}, 32'(bif.timeout),  32'(m_to));
    endtask

    task automatic step(input logic [NREQ-1:0] r);
        bif.req = r;
        @(posedge clock);
        model_edge(r);
        #1;
    endtask

    task automatic do_reset();
        bif.req = '0;
        resetn  = 1'b0;
        #1;
        chk("rst_grant",   32'(bif.grant),    32'd0);
        chk("rst_id",      32'(bif.grant_id), 32'd0);
        chk("rst_busy",    32'(bif.bus_busy), 32'd0);
        chk("rst_timeout", 32'(bif.timeout),  32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NREQ-1:0] r;
        logic [31:0]     eg;
        int              n5;
        int              nto;

        bif.req = '0;
        model_reset();

        tbl.push_back('{1'b1, 24'h100000, 20, 1'b1});
        tbl.push_back('{1'b0, 24'h100000, 20, 1'b1});
        tbl.push_back('{1'b0, 24'h100008, 20, 1'b1});
        tbl.push_back('{1'b0, 24'h000000,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h000008,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h400008, 22, 1'b1});
        tbl.push_back('{1'b1, 24'h200008,  3, 1'b1});
        tbl.push_back('{1'b0, 24'h200008,  3, 1'b1});
        tbl.push_back('{1'b0, 24'h200008,  3, 1'b1});
        tbl.push_back('{1'b0, 24'h200008,  3, 1'b1});
        tbl.push_back('{1'b0, 24'h200000,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h200000,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h200000, 21, 1'b1});
        tbl.push_back('{1'b1, 24'h800000, 23, 1'b1});
        tbl.push_back('{1'b0, 24'h400001,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h400001,  0, 1'b0});
        tbl.push_back('{1'b0, 24'h400001,  0, 1'b1});

        for (int v = 0; v < tbl.size(); v++) begin
            if (tbl[v].rst) do_reset();
            step(tbl[v].req);
            eg = tbl[v].exp_busy ? (32'd1 << tbl[v].exp_id) : 32'd0;
            chk("vec_grant",   32'(bif.grant),    eg);
            chk("vec_id",      32'(bif.grant_id), 32'(tbl[v].exp_id));
            chk("vec_busy",    32'(bif.bus_busy), 32'(tbl[v].exp_busy));
            chk("vec_timeout", 32'(bif.timeout),  32'd0);
        end

        // Asynchronous reset mid-GRANT, with ptr moved away from 0 beforehand.
        do_reset();
        step(24'h000400);
        step(24'h000000);
        step(24'h000000);
        step(24'h001000);
        chk("async_pre_id", 32'(bif.grant_id), 32'd12);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_grant", 32'(bif.grant),    32'd0);
        chk("async_busy",  32'(bif.bus_busy), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
        step(24'h001004);
        chk("async_restart_id", 32'(bif.grant_id), 32'd2);
        check_model("async_restart");

        // Long hold by source 5 with source 6 waiting.
        do_reset();
        n5  = 0;
        nto = 0;
        for (int c = 0; c < 20; c++) begin
            step(24'h000060);
            check_model("hold");
            if (bif.bus_busy === 1'b1 && bif.grant_id === 5'd5) n5++;
            if (bif.timeout === 1'b1) nto++;
        end
        chk("hold_cycles5",   32'(n5),           TO_EN ? 32'd16 : 32'd20);
        chk("hold_to_pulses", 32'(nto),          TO_EN ? 32'd1  : 32'd0);
        chk("hold_final_id",  32'(bif.grant_id), TO_EN ? 32'd6  : 32'd5);

        // Randomized traffic: each request bit toggles now and then.
        do_reset();
        r = '0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            step(r);
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
